// File: rtl/fir_filter.sv
// fir_filter -- fixed-coefficient direct-form FIR low-pass filter.
//
// Each sample accepted while data_valid is high produces one signed output on
// y_out, and valid_out pulses once for it. Arithmetic is full precision; the
// accumulator width is derived from the coefficient set so that no overflow
// can occur before the final resize to OUT_W.
//
// Parameters
//   DATA_W  input sample width (signed)
//   COEF_W  coefficient width (signed)
//   NTAPS   number of taps
//   OUT_W   output width (signed)
//   COEFFS  packed coefficients, c[0] in the MS field (multiplies newest sample)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   data_valid  x_in carries a new sample this cycle
//   x_in        signed input sample
//   y_out       signed filtered output, registered
//   valid_out   one-cycle strobe per accepted sample
//
// Build option
//   FIR_PIPELINE_EN  adds a product register stage ahead of the adder tree;
//                    latency goes from 1 to 2 clocks, results are unchanged.

module fir_filter #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 8,
    parameter int OUT_W  = 16,
    parameter logic [NTAPS*COEF_W-1:0] COEFFS =
        {8'sd3, 8'sd10, 8'sd24, 8'sd35, 8'sd35, 8'sd24, 8'sd10, 8'sd3}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     valid_out
);

    localparam int PROD_W = DATA_W + COEF_W;

    function automatic logic signed [COEF_W-1:0] coef(input int unsigned k);
        return COEFFS[(NTAPS-1-k)*COEF_W +: COEF_W];
    endfunction

    // Smallest signed width that holds sum|c| * 2^(DATA_W-1).
    function automatic int acc_width();
        int s;
        int ci;
        s = 0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            ci = int'(coef(i));
            s += (ci < 0) ? -ci : ci;
        end
        return $clog2(s * (1 << (DATA_W - 1))) + 1;
    endfunction

    localparam int ACC_W = acc_width();

    // History holds x(n-1)..x(n-NTAPS+1); the newest sample is x_in itself.
    logic signed [DATA_W-1:0] hist [NTAPS-1];
    logic signed [DATA_W-1:0] tap  [NTAPS];
    logic signed [PROD_W-1:0] prod [NTAPS];
    logic signed [ACC_W-1:0]  acc;

`ifdef FIR_PIPELINE_EN
    logic signed [PROD_W-1:0] prod_q [NTAPS];
    logic                     prod_valid;
`endif

    always_comb begin
        tap[0] = x_in;
        for (int unsigned k = 1; k < NTAPS; k++) begin
            tap[k] = hist[k-1];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NTAPS; k++) begin
            prod[k] = PROD_W'(tap[k]) * PROD_W'(coef(k));
        end
    end

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
`ifdef FIR_PIPELINE_EN
            acc += ACC_W'(prod_q[k]);
`else
            acc += ACC_W'(prod[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NTAPS - 1; k++) begin
                hist[k] <= '0;
            end
        end else if (data_valid) begin
            hist[0] <= x_in;
            for (int unsigned k = 1; k < NTAPS - 1; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

`ifdef FIR_PIPELINE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                prod_q[k] <= '0;
            end
            prod_valid <= 1'b0;
            y_out      <= '0;
            valid_out  <= 1'b0;
        end else begin
            prod_valid <= data_valid;
            if (data_valid) begin
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    prod_q[k] <= prod[k];
                end
            end
            valid_out <= prod_valid;
            if (prod_valid) begin
                y_out <= OUT_W'(acc);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            y_out     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= data_valid;
            if (data_valid) begin
                y_out <= OUT_W'(acc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter -- directed, table-driven bench for fir_filter (default build,
// latency 1). Each table record is applied for one clock and the outputs are
// compared just after that clock's rising edge. A continuous sine stream is
// then checked against a bench-side convolution model.

module tb_fir_filter;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_valid;
    logic [7:0]        x_in;
    logic [15:0]       y_out;
    logic              valid_out;

    always #5 clk = ~clk;

    fir_filter dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .x_in       (x_in),
        .y_out      (y_out),
        .valid_out  (valid_out)
    );

    typedef struct {
        string name;
        logic  rst;
        logic  dv;
        int    x;
        logic  x_unknown;
        logic  exp_valid;
        int    exp_y;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input string nm, input logic r, input logic dv, input int x,
                       input logic xu, input logic ev, input int ey);
        vec_t v;
        v.name = nm; v.rst = r; v.dv = dv; v.x = x; v.x_unknown = xu;
        v.exp_valid = ev; v.exp_y = ey;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic dv, input logic [7:0] x);
        @(negedge clk);
        rst        = r;
        data_valid = dv;
        x_in       = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int coef [8] = '{3, 10, 24, 35, 35, 24, 10, 3};
        int imp  [8] = '{3, 10, 24, 35, 35, 24, 10, 3};
        int pos  [9] = '{381, 1651, 4699, 9144, 13589, 16637, 17907, 18288, 18288};
        int neg  [9] = '{-384, -1664, -4736, -9216, -13696, -16768, -18048, -18432, -18432};
        int hist [8];
        int maxabs;

        rst = 1'b1; data_valid = 1'b0; x_in = '0;

        // Reset state, with a sample offered during reset (dropped).
        add("reset", 1, 1, 100, 0, 0, 0);
        add("reset2", 1, 0, 0, 0, 0, 0);

        // Impulse, continuous valid.
        for (int i = 0; i < 8; i++) add($sformatf("imp%0d", i), 0, 1, (i == 0) ? 1 : 0, 0, 1, imp[i]);
        add("imp_tail", 0, 1, 0, 0, 1, 0);
        add("idle_hold", 0, 0, 55, 0, 0, 0);

        // Positive full-scale step.
        for (int i = 0; i < 9; i++) add($sformatf("pos%0d", i), 0, 1, 127, 0, 1, pos[i]);
        add("pos_idle", 0, 0, 0, 1, 0, 18288);

        // Reset mid-stream: sample in reset cycle dropped, history cleared.
        add("mid_rst", 1, 1, 127, 0, 0, 0);
        add("post_rst", 0, 1, 127, 0, 1, 381);

        // Negative full scale from a clean start.
        add("rst_neg", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add($sformatf("neg%0d", i), 0, 1, -128, 0, 1, neg[i]);

        // Gapped impulse with unknown x_in during gaps.
        add("rst_gap", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            add($sformatf("gap_v%0d", i), 0, 1, (i == 0) ? 1 : 0, 0, 1, imp[i]);
            add($sformatf("gap_h%0d", i), 0, 0, 0, 1, 0, imp[i]);
        end

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].dv, vq[i].x_unknown ? 8'bx : 8'(vq[i].x));
            check({vq[i].name, "_valid"}, int'(valid_out), int'(vq[i].exp_valid));
            check({vq[i].name, "_y"}, int'($signed(y_out)), vq[i].exp_y);
        end

        // Sine stream against a convolution model.
        drive(1'b1, 1'b0, 8'h00);
        check("sine_rst_valid", int'(valid_out), 0);
        foreach (hist[k]) hist[k] = 0;
        maxabs = 0;
        for (int n = 0; n < 1000; n++) begin
            int s;
            int e;
            s = $rtoi($floor(127.0 * $sin(2.0 * 3.14159265358979 * n / 1000.0) + 0.5));
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
            e = 0;
            for (int k = 0; k < 8; k++) e += coef[k] * hist[k];
            drive(1'b0, 1'b1, 8'(s));
            check($sformatf("sine%0d_valid", n), int'(valid_out), 1);
            check($sformatf("sine%0d_y", n), int'($signed(y_out)), e);
            if ($signed(y_out) > maxabs) maxabs = int'($signed(y_out));
            if (-$signed(y_out) > maxabs) maxabs = -int'($signed(y_out));
        end
        check("sine_max_le_18288", int'(maxabs <= 18288), 1);
        drive(1'b0, 1'b0, 8'h00);
        check("sine_end_valid", int'(valid_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
